divider: RTL and testbench

Iterative 32-step restoring divider for the execute stage, the subtract-driven counterpart to the single-cycle adder. It accepts a dividend and a divisor through a start pulse and holds `busy_o` while it works. When finished it presents quotient, remainder and the same zero/positive/negative/overflow flag set the adder produces, so the flag path into the condition logic is shared. It runs one division at a time and is stalled around by the pipeline control through `busy_o`/`valid_o`.

---
 rtl/divider.sv | 150 +++++++++++++++
 tb/tb_divider.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/divider.sv
// Iterative restoring divider: one quotient bit per CALC cycle, with sign handling
// and adder-compatible result flags. Signed support is built only when DIVIDER_SIGNED_EN is defined.
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] opr0_i,
  input  logic [WIDTH-1:0] opr1_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             zero_flag_o,
  output logic             pos_flag_o,
  output logic             neg_flag_o,
  output logic             overflow_flag_o,
  output logic             div_by_zero_o,
  output logic [2:0]       state_o
);

  // Handshake: start_i is accepted only in IDLE/DONE when flush_i is low; busy_o is
  // high while an operation is in flight; valid_o pulses for the single DONE cycle
  // and the result outputs hold until the next DONE.

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_e;

`ifdef DIVIDER_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [5:0]       LAST_STEP = 6'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [5:0]       cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q;
  logic [WIDTH-1:0] dvd_q;   // dividend shifts out of the top, quotient bits shift in
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic             neg_quo_q, neg_rem_q, ovf_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] res_quo, res_rem;
  logic             res_of, res_dz;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i) state_d = PREP;
      PREP: state_d = (b_q == '0) ? DONE : CALC;
      CALC: if (cnt_q == LAST_STEP) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = start_i ? PREP : IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  assign busy_o  = (state_q == PREP) || (state_q == CALC) || (state_q == FIX);
  assign valid_o = (state_q == DONE);
  assign state_o = state_q;

  always_comb begin
    a_neg  = sgn_q & a_q[WIDTH-1];
    b_neg  = sgn_q & b_q[WIDTH-1];
    a_abs  = a_neg ? (~a_q + 1'b1) : a_q;
    b_abs  = b_neg ? (~b_q + 1'b1) : b_q;
    rem_sh = {rem_q, dvd_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    // PREP can only reach DONE through the zero-divisor path.
    res_dz = (state_q == PREP);
    if (res_dz) begin
      res_quo = '1;
      res_rem = a_q;
      res_of  = 1'b0;
    end else begin
      res_quo = neg_quo_q ? (~dvd_q + 1'b1) : dvd_q;
      res_rem = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
      res_of  = ovf_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      a_q             <= '0;
      b_q             <= '0;
      sgn_q           <= 1'b0;
      dvd_q           <= '0;
      dvs_q           <= '0;
      rem_q           <= '0;
      neg_quo_q       <= 1'b0;
      neg_rem_q       <= 1'b0;
      ovf_q           <= 1'b0;
      quotient_o      <= '0;
      remainder_o     <= '0;
      zero_flag_o     <= 1'b0;
      pos_flag_o      <= 1'b0;
      neg_flag_o      <= 1'b0;
      overflow_flag_o <= 1'b0;
      div_by_zero_o   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == PREP) begin
        a_q   <= opr0_i;
        b_q   <= opr1_i;
        sgn_q <= signed_i & SIGNED_EN;
      end
      case (state_q)
        PREP: begin
          dvd_q     <= a_abs;
          dvs_q     <= b_abs;
          rem_q     <= '0;
          cnt_q     <= '0;
          neg_quo_q <= a_neg ^ b_neg;
          neg_rem_q <= a_neg;
          // The magnitude path already yields MOST_NEG rem 0 here; only the flag is extra.
          ovf_q     <= sgn_q && (a_q == MOST_NEG) && (b_q == '1);
        end
        CALC: begin
          if (!diff[WIDTH]) rem_q <= diff[WIDTH-1:0];
          else              rem_q <= rem_sh[WIDTH-1:0];
          dvd_q <= {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
          cnt_q <= cnt_q + 6'd1;
        end
        default: ;
      endcase
      if (state_d == DONE && state_q != DONE) begin
        quotient_o      <= res_quo;
        remainder_o     <= res_rem;
        zero_flag_o     <= (res_quo == '0);
        pos_flag_o      <= ~res_quo[WIDTH-1];
        neg_flag_o      <= res_quo[WIDTH-1];
        overflow_flag_o <= res_of;
        div_by_zero_o   <= res_dz;
      end
    end
  end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: drivers push expected results, a negedge monitor
// pops and compares them (value, flags and arrival cycle) whenever valid_o is seen.
module tb_divider;
  localparam int W  = 32;
  localparam int EW = 2 * W + 5 + 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sgn = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, valid, zf, pf, nf, of, dz;
  logic [W-1:0] quo, rem;
  logic [2:0]   state;

  divider #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .signed_i(sgn), .flush_i(flush),
    .opr0_i(a), .opr1_i(b), .busy_o(busy), .valid_o(valid),
    .quotient_o(quo), .remainder_o(rem), .zero_flag_o(zf), .pos_flag_o(pf),
    .neg_flag_o(nf), .overflow_flag_o(of), .div_by_zero_o(dz), .state_o(state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  logic [W-1:0]  last_q = '0;
  logic [W-1:0]  last_r = '0;
  logic [4:0]    last_f = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got valid=1 want no result (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("quotient",  64'(quo), 64'(mon_e[EW-1 -: W]));
        check("remainder", 64'(rem), 64'(mon_e[EW-W-1 -: W]));
        check("flags_zpnod", 64'({zf, pf, nf, of, dz}), 64'(mon_e[36:32]));
        check("valid_cycle", 64'(cyc), 64'(mon_e[31:0]));
        last_q = mon_e[EW-1 -: W];
        last_r = mon_e[EW-W-1 -: W];
        last_f = mon_e[36:32];
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; start is sampled on the following posedge.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic [4:0] ef, input bit push);
    int lat;
    lat = (y == '0) ? 1 : 34;
    a = x;
    b = y;
    sgn = s;
    start = 1'b1;
    if (push) exp_q.push_back({eq, er, ef, 32'(cyc + 1 + lat)});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d pending results want 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string name, input logic [W-1:0] eq,
                                    input logic [W-1:0] er, input logic [4:0] ef);
    check({name, "_busy_valid"}, 64'({busy, valid}), 64'(0));
    check({name, "_quotient"},   64'(quo), 64'(eq));
    check({name, "_remainder"},  64'(rem), 64'(er));
    check({name, "_flags"},      64'({zf, pf, nf, of, dz}), 64'(ef));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset", '0, '0, 5'b00000);
    rst_n = 1'b1;
    @(negedge clk);

    // flags are {zf, pf, nf, of, dz}
    issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 5'b01000, 1);
    wait_done();

`ifdef DIVIDER_SIGNED_EN
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 5'b00100, 1);
`else
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 5'b01000, 1);
`endif
    wait_done();

    issue(32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 5'b00101, 1);
    wait_done();

`ifdef DIVIDER_SIGNED_EN
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 5'b00110, 1);
`else
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 5'b11000, 1);
`endif
    wait_done();

    // flush ten cycles into an operation: no result, outputs keep the previous one
    issue(32'd1000, 32'd3, 1'b0, '0, '0, 5'b0, 0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_idle_outputs("flush", last_q, last_r, last_f);
    repeat (40) @(negedge clk);

    issue(32'd5, 32'd5, 1'b0, 32'd1, 32'd0, 5'b01000, 1);
    wait_done();

    // reset in the middle of CALC clears every result output
    issue(32'd1000, 32'd3, 1'b0, '0, '0, 5'b0, 0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset", '0, '0, 5'b00000);
    rst_n = 1'b1;
    last_q = '0;
    last_r = '0;
    last_f = '0;
    repeat (40) @(negedge clk);

    issue(32'd5, 32'd5, 1'b0, 32'd1, 32'd0, 5'b01000, 1);
    wait_done();

    // start while busy with other operands is ignored
    issue(32'd200, 32'd10, 1'b0, 32'd20, 32'd0, 5'b01000, 1);
    repeat (5) @(negedge clk);
    a = 32'd9;
    b = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (40) @(negedge clk);

    // start during DONE: second result exactly 35 cycles after the first
    issue(32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 5'b01000, 1);
    n = 0;
    while (!valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL b2b_first_valid: got no valid want valid within 100 cycles");
    end
    issue(32'hFFFF_FFFF, 32'd16, 1'b0, 32'h0FFF_FFFF, 32'd15, 5'b01000, 1);
    wait_done();
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
